// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: single-cycle or wait-stated OKAY transfers, two-cycle ERROR
// response for oversize, misaligned or out-of-range accesses.
module ahb_sram_slave #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned MEM_DEPTH   = 1024,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                  hclk,
   input  logic                  hresetn,
   input  logic                  hselx,
   input  logic [ADDR_WIDTH-1:0] haddr,
   input  logic [1:0]            htrans,
   input  logic                  hwrite,
   input  logic [2:0]            hsize,
   input  logic [2:0]            hburst,
   input  logic [3:0]            hprot,
   input  logic                  hmastlock,
   input  logic                  hready,
   input  logic [DATA_WIDTH-1:0] hwdata,
   output logic                  hreadyout,
   output logic [DATA_WIDTH-1:0] hrdata,
   output logic                  hresp
);

   localparam int unsigned IDX_W   = $clog2(MEM_DEPTH);
   localparam logic [2:0]  WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

   typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

   state_t                state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic                  dphase_q, dphase_d;
   logic [IDX_W+1:0]      addr_q;
   logic                  write_q;
   logic [2:0]            size_q;
   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

   logic       slv_ready;
   logic       accept;
   logic       err_a;
   logic       xfer_final;
   logic [3:0] be;
   logic       unused_attrs;

   assign unused_attrs = ^{htrans[0], hburst, hprot, hmastlock};

   assign slv_ready = (state_q == IDLE) || (state_q == ERR2);
   assign accept    = hselx && hready && htrans[1] && slv_ready;

   // MEM_DEPTH is a power of two, so any set bit above the index field is out of range
   assign err_a = (hsize > 3'd2)
                || ((hsize == 3'd1) && haddr[0])
                || ((hsize == 3'd2) && (haddr[1:0] != 2'b00))
                || (|haddr[ADDR_WIDTH-1:IDX_W+2]);

   // An OKAY data phase completes in the IDLE cycle that follows its wait states
   assign xfer_final = (state_q == IDLE) && dphase_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dphase_d  = dphase_q;
      hreadyout = 1'b1;
      hresp     = 1'b0;
      case (state_q)
         IDLE, ERR2: begin
            hresp    = (state_q == ERR2);
            state_d  = IDLE;
            dphase_d = 1'b0;
            if (accept) begin
               if (err_a) begin
                  state_d = ERR1;
               end else begin
                  dphase_d = 1'b1;
                  if (WAIT_STATES > 0) begin
                     state_d = WAIT;
                     cnt_d   = WS_LOAD;
                  end
               end
            end
         end
         WAIT: begin
            hreadyout = 1'b0;
            if (cnt_q == 3'd0) state_d = IDLE;
            else               cnt_d   = cnt_q - 3'd1;
         end
         ERR1: begin
            hreadyout = 1'b0;
            hresp     = 1'b1;
            state_d   = ERR2;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         dphase_q <= 1'b0;
         addr_q   <= '0;
         write_q  <= 1'b0;
         size_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dphase_q <= dphase_d;
         if (accept) begin
            addr_q  <= haddr[IDX_W+1:0];
            write_q <= hwrite;
            size_q  <= hsize;
         end
      end
   end

   always_comb begin
      be = '0;
      case (size_q)
         3'd0:    be[addr_q[1:0]] = 1'b1;
         3'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
   end

   always_ff @(posedge hclk) begin
      if (xfer_final && write_q) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (be[b]) mem_q[addr_q[IDX_W+1:2]][8*b +: 8] <= hwdata[8*b +: 8];
         end
      end
   end

   assign hrdata = (xfer_final && !write_q) ? mem_q[addr_q[IDX_W+1:2]] : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one instance with zero wait states, one with three.
module tb_ahb_sram_slave;

   localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

   logic        hclk = 1'b0;
   logic        hresetn;
   logic        sel, use3;
   logic [31:0] haddr, hwdata;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize, hburst;
   logic [3:0]  hprot;
   logic        hmastlock;

   logic        hsel0, hsel3, rdy0, rdy3, resp0, resp3, rdy_m, resp_m;
   logic [31:0] rd0, rd3, rd_m;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 hclk = ~hclk;

   assign hsel0  = sel & ~use3;
   assign hsel3  = sel & use3;
   assign rdy_m  = use3 ? rdy3  : rdy0;
   assign resp_m = use3 ? resp3 : resp0;
   assign rd_m   = use3 ? rd3   : rd0;

   ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
      .hclk(hclk), .hresetn(hresetn), .hselx(hsel0), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock),
      .hready(rdy0), .hwdata(hwdata), .hreadyout(rdy0), .hrdata(rd0), .hresp(resp0));

   ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(3)) u_dut3 (
      .hclk(hclk), .hresetn(hresetn), .hselx(hsel3), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock),
      .hready(rdy3), .hwdata(hwdata), .hreadyout(rdy3), .hrdata(rd3), .hresp(resp3));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic bus_idle();
      sel    = 1'b0;
      htrans = T_IDLE;
      haddr  = '0;
      hwrite = 1'b0;
      hsize  = 3'd2;
   endtask

   task automatic addr_ph(input logic [31:0] a, input logic w, input logic [2:0] sz,
                          input logic [1:0] tr);
      sel    = 1'b1;
      haddr  = a;
      hwrite = w;
      hsize  = sz;
      htrans = tr;
   endtask

   // Single NONSEQ transfer; reports wait count, first/last-cycle hresp and final hrdata
   task automatic do_xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                          input logic [31:0] wd, output logic [31:0] rd, output int nw,
                          output logic rf, output logic rl);
      logic done = 1'b0;
      nw = 0; rf = 1'b0; rl = 1'b0; rd = '0;
      addr_ph(a, w, sz, T_NSEQ);
      tick();
      bus_idle();
      hwdata = wd;
      for (int i = 0; i < 20; i++) begin
         @(negedge hclk);
         if (i == 0) rf = resp_m;
         if (rdy_m) begin
            done = 1'b1;
            break;
         end
         nw++;
         tick();
      end
      rd = rd_m;
      rl = resp_m;
      check("xfer_done", 32'(done), 32'd1);
      tick();
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] rd;
      int          nw;
      logic        rf, rl;
      do_xfer(a, 1'b0, 3'd2, 32'h0, rd, nw, rf, rl);
      check(tag, rd, exp);
   endtask

   initial begin
      logic [31:0] rd;
      int          nw;
      logic        rf, rl;
      logic [31:0] bdat [4];

      hresetn = 1'b0; use3 = 1'b0; hwdata = '0;
      hburst = 3'b001; hprot = 4'b0011; hmastlock = 1'b0;
      bus_idle();
      repeat (2) @(posedge hclk);
      @(negedge hclk);
      check("rst_rdy0", 32'(rdy0), 32'd1);
      check("rst_resp0", 32'(resp0), 32'd0);
      check("rst_rd0", rd0, 32'h0);
      check("rst_rdy3", 32'(rdy3), 32'd1);
      hresetn = 1'b1;
      tick();

      // back-to-back write then read, zero wait states
      addr_ph(32'h10, 1'b1, 3'd2, T_NSEQ);
      tick();
      hwdata = 32'hDEADBEEF;
      addr_ph(32'h10, 1'b0, 3'd2, T_NSEQ);
      @(negedge hclk);
      check("s1_wr_rdy", 32'(rdy0), 32'd1);
      check("s1_wr_resp", 32'(resp0), 32'd0);
      tick();
      bus_idle();
      hwdata = '0;
      @(negedge hclk);
      check("s1_rd_rdy", 32'(rdy0), 32'd1);
      check("s1_rd_data", rd0, 32'hDEADBEEF);
      tick();
      @(negedge hclk);
      check("s1_idle_rdata", rd0, 32'h0);
      check("s1_idle_rdy", 32'(rdy0), 32'd1);
      tick();

      // three wait states
      use3 = 1'b1;
      do_xfer(32'h0, 1'b1, 3'd2, 32'hCAFEF00D, rd, nw, rf, rl);
      check("s2_wr_waits", 32'(nw), 32'd3);
      do_xfer(32'h0, 1'b0, 3'd2, 32'h0, rd, nw, rf, rl);
      check("s2_rd_waits", 32'(nw), 32'd3);
      check("s2_rd_resp", 32'(rl), 32'd0);
      check("s2_rd_data", rd, 32'hCAFEF00D);

      // sub-word writes keep untouched lanes
      use3 = 1'b0;
      do_xfer(32'h20, 1'b1, 3'd2, 32'h11223344, rd, nw, rf, rl);
      do_xfer(32'h21, 1'b1, 3'd0, 32'h5555AA55, rd, nw, rf, rl);
      check("s3_byte_waits", 32'(nw), 32'd0);
      rd_chk("s3_byte_rd", 32'h20, 32'h1122AA44);
      do_xfer(32'h22, 1'b1, 3'd1, 32'hBEEF1234, rd, nw, rf, rl);
      rd_chk("s3_half_rd", 32'h20, 32'hBEEFAA44);

      // error responses leave memory alone
      do_xfer(32'h0, 1'b1, 3'd2, 32'h01020304, rd, nw, rf, rl);
      do_xfer(32'h2, 1'b1, 3'd2, 32'hFFFFFFFF, rd, nw, rf, rl);
      check("s4_mis_waits", 32'(nw), 32'd1);
      check("s4_mis_resp1", 32'(rf), 32'd1);
      check("s4_mis_resp2", 32'(rl), 32'd1);
      do_xfer(32'h1000, 1'b1, 3'd2, 32'hFFFFFFFF, rd, nw, rf, rl);
      check("s4_oor_waits", 32'(nw), 32'd1);
      check("s4_oor_resp1", 32'(rf), 32'd1);
      check("s4_oor_resp2", 32'(rl), 32'd1);
      do_xfer(32'h1000, 1'b0, 3'd2, 32'h0, rd, nw, rf, rl);
      check("s4_oor_rdata", rd, 32'h0);
      check("s4_oor_rresp", 32'(rl), 32'd1);
      do_xfer(32'h8, 1'b0, 3'd3, 32'h0, rd, nw, rf, rl);
      check("s4_size3_resp", 32'(rf), 32'd1);
      rd_chk("s4_mem_kept", 32'h0, 32'h01020304);

      // INCR4 write with BUSY after beat 2
      bdat[0] = 32'h11110000; bdat[1] = 32'h22220001;
      bdat[2] = 32'h33330002; bdat[3] = 32'h44440003;
      addr_ph(32'h40, 1'b1, 3'd2, T_NSEQ);
      tick();
      hwdata = bdat[0];
      addr_ph(32'h44, 1'b1, 3'd2, T_SEQ);
      @(negedge hclk);
      check("s5_b0_rdy", 32'(rdy0), 32'd1);
      tick();
      hwdata = bdat[1];
      addr_ph(32'h48, 1'b1, 3'd2, T_BUSY);
      @(negedge hclk);
      check("s5_b1_rdy", 32'(rdy0), 32'd1);
      tick();
      hwdata = 32'hBADBAD00;
      addr_ph(32'h48, 1'b1, 3'd2, T_SEQ);
      @(negedge hclk);
      check("s5_busy_rdy", 32'(rdy0), 32'd1);
      check("s5_busy_resp", 32'(resp0), 32'd0);
      tick();
      hwdata = bdat[2];
      addr_ph(32'h4C, 1'b1, 3'd2, T_SEQ);
      @(negedge hclk);
      check("s5_b2_rdy", 32'(rdy0), 32'd1);
      tick();
      hwdata = bdat[3];
      bus_idle();
      @(negedge hclk);
      check("s5_b3_rdy", 32'(rdy0), 32'd1);
      tick();
      for (int i = 0; i < 4; i++) rd_chk("s5_burst_rd", 32'h40 + 32'(4*i), bdat[i]);

      // reset during the second wait cycle aborts the write
      use3 = 1'b1;
      do_xfer(32'h80, 1'b1, 3'd2, 32'h12345678, rd, nw, rf, rl);
      addr_ph(32'h80, 1'b1, 3'd2, T_NSEQ);
      tick();
      bus_idle();
      hwdata = 32'hFFFFFFFF;
      @(negedge hclk);
      check("s6_wait1", 32'(rdy3), 32'd0);
      tick();
      @(negedge hclk);
      check("s6_wait2", 32'(rdy3), 32'd0);
      hresetn = 1'b0;
      #1;
      check("s6_rst_rdy", 32'(rdy3), 32'd1);
      check("s6_rst_resp", 32'(resp3), 32'd0);
      check("s6_rst_rdata", rd3, 32'h0);
      tick();
      check("s6_rst_rdy_hold", 32'(rdy3), 32'd1);
      #2;
      hresetn = 1'b1;
      tick();
      @(negedge hclk);
      check("s6_post_rdy", 32'(rdy3), 32'd1);
      check("s6_post_resp", 32'(resp3), 32'd0);
      do_xfer(32'h80, 1'b0, 3'd2, 32'h0, rd, nw, rf, rl);
      check("s6_word_kept", rd, 32'h12345678);
      check("s6_rd_waits", 32'(nw), 32'd3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
